// File: rtl/nes_pad_reader.sv
// Dual NES controller reader: drives the shared latch/clock lines, shifts in
// both pads' 8 buttons and publishes active-high snapshots once per frame.
module nes_pad_reader #(
    parameter int HALF_PERIOD = 6,
    parameter int POLL_GAP    = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       pad1_data,
    input  logic       pad2_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] pad1_value,
    output logic [7:0] pad2_value,
    output logic       update,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LATCH    = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        COMMIT   = 3'd4,
        GAP      = 3'd5
    } state_t;

    localparam logic [8:0]  LATCH_LAST = 9'(2 * HALF_PERIOD - 1);
    localparam logic [8:0]  HALF_LAST  = 9'(HALF_PERIOD - 1);
    localparam logic [15:0] GAP_LAST   = 16'(POLL_GAP - 1);

    state_t      state_r;
    state_t      state_next_s;
    logic [8:0]  phase_cnt_r;
    logic [15:0] gap_cnt_r;
    logic [2:0]  bit_idx_r;
    logic [7:0]  shift1_r;
    logic [7:0]  shift2_r;
    logic        sample_s;
    logic        state_change_s;

    assign state_change_s = (state_next_s != state_r);

    // Next-state decode; sample_s marks the last cycle of a SHIFT_LO phase.
    always_comb begin
        state_next_s = state_r;
        sample_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_next_s = LATCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LATCH: begin
                if (phase_cnt_r == LATCH_LAST) begin
                    state_next_s = SHIFT_LO;
                end else begin
                    state_next_s = LATCH;
                end
            end
            SHIFT_LO: begin
                if (phase_cnt_r == HALF_LAST) begin
                    state_next_s = SHIFT_HI;
                    sample_s     = 1'b1;
                end else begin
                    state_next_s = SHIFT_LO;
                end
            end
            SHIFT_HI: begin
                if (phase_cnt_r != HALF_LAST) begin
                    state_next_s = SHIFT_HI;
                end else if (bit_idx_r == 3'd7) begin
                    state_next_s = COMMIT;
                end else begin
                    state_next_s = SHIFT_LO;
                end
            end
            COMMIT: begin
                state_next_s = GAP;
            end
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = GAP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Phase/gap counters restart on every state entry and only run in timed states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_cnt_r <= 9'd0;
            gap_cnt_r   <= 16'd0;
        end else begin
            if (!state_change_s && (state_r == LATCH || state_r == SHIFT_LO || state_r == SHIFT_HI)) begin
                phase_cnt_r <= phase_cnt_r + 9'd1;
            end else begin
                phase_cnt_r <= 9'd0;
            end
            if (!state_change_s && state_r == GAP) begin
                gap_cnt_r <= gap_cnt_r + 16'd1;
            end else begin
                gap_cnt_r <= 16'd0;
            end
        end
    end

    // Bit index and serial capture; bit i lands at position 7-i so A ends up in bit 7.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_idx_r <= 3'd0;
            shift1_r  <= 8'hFF;
            shift2_r  <= 8'hFF;
        end else begin
            if (state_r == LATCH) begin
                bit_idx_r <= 3'd0;
            end else if (state_r == SHIFT_HI && state_next_s == SHIFT_LO) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end else begin
                bit_idx_r <= bit_idx_r;
            end
            if (sample_s) begin
                shift1_r[3'd7 - bit_idx_r] <= pad1_data;
                shift2_r[3'd7 - bit_idx_r] <= pad2_data;
            end else begin
                shift1_r <= shift1_r;
                shift2_r <= shift2_r;
            end
        end
    end

    // Outputs are registered from the next state so they align with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pad_latch  <= 1'b0;
            pad_clk    <= 1'b0;
            update     <= 1'b0;
            busy       <= 1'b0;
            pad1_value <= 8'h00;
            pad2_value <= 8'h00;
        end else begin
            pad_latch <= (state_next_s == LATCH);
            pad_clk   <= (state_next_s == SHIFT_HI);
            update    <= (state_next_s == COMMIT);
            busy      <= (state_next_s == LATCH) || (state_next_s == SHIFT_LO) ||
                         (state_next_s == SHIFT_HI) || (state_next_s == COMMIT);
            if (state_next_s == COMMIT) begin
                pad1_value <= ~shift1_r;
                pad2_value <= ~shift2_r;
            end else begin
                pad1_value <= pad1_value;
                pad2_value <= pad2_value;
            end
        end
    end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed self-checking bench for nes_pad_reader with two behavioural NES pads.
module tb_nes_pad_reader;

    localparam int HP      = 2;
    localparam int PG      = 4;
    localparam int FRAME   = 2 * HP + 16 * HP + 1;
    localparam int SPACING = FRAME + PG + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       pad1_data;
    logic       pad2_data;
    logic       pad_latch;
    logic       pad_clk;
    logic [7:0] pad1_value;
    logic [7:0] pad2_value;
    logic       update;
    logic       busy;

    logic [7:0] p1_btn = 8'h00;
    logic [7:0] p2_btn = 8'h00;
    logic [3:0] pidx = 4'd0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int upd_cnt = 0;
    int overlap_cnt = 0;

    nes_pad_reader #(.HALF_PERIOD(HP), .POLL_GAP(PG)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pad1_data  (pad1_data),
        .pad2_data  (pad2_data),
        .pad_latch  (pad_latch),
        .pad_clk    (pad_clk),
        .pad1_value (pad1_value),
        .pad2_value (pad2_value),
        .update     (update),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pads: latch resets the bit pointer, each pad_clk rise advances it; data is active-low.
    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) pidx <= 4'd0;
        else if (pidx < 4'd8) pidx <= pidx + 4'd1;
    end

    assign pad1_data = (pidx < 4'd8) ? ~p1_btn[3'd7 - pidx[2:0]] : 1'b1;
    assign pad2_data = (pidx < 4'd8) ? ~p2_btn[3'd7 - pidx[2:0]] : 1'b1;

    always @(negedge clk) begin
        if (update) upd_cnt <= upd_cnt + 1;
        if (pad_latch && pad_clk) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_latch(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (pad_latch) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq(tag, seen, 1'b1);
    endtask

    task automatic wait_update(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (update) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq(tag, seen, 1'b1);
    endtask

    // Records one frame from the first LATCH cycle and compares against the ideal waveform.
    task automatic trace_frame();
        logic [FRAME-1:0] o_latch, o_clk, o_upd, o_busy;
        logic [FRAME-1:0] e_latch, e_clk, e_upd, e_busy;
        int rises;
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) tick();
            o_latch[c] = pad_latch;
            o_clk[c]   = pad_clk;
            o_upd[c]   = update;
            o_busy[c]  = busy;
            e_latch[c] = (c < 2 * HP);
            e_clk[c]   = (c >= 2 * HP) && (c < FRAME - 1) && (((c - 2 * HP) % (2 * HP)) >= HP);
            e_upd[c]   = (c == FRAME - 1);
            e_busy[c]  = 1'b1;
        end
        rises = 0;
        for (int c = 1; c < FRAME; c++) begin
            if (o_clk[c] && !o_clk[c - 1]) rises++;
        end
        check_eq("latch_wave", o_latch, e_latch);
        check_eq("clk_wave", o_clk, e_clk);
        check_eq("update_wave", o_upd, e_upd);
        check_eq("busy_wave", o_busy, e_busy);
        check_eq("clk_pulses", rises, 8);
    endtask

    initial begin
        int t_a, t_b, t_c, u0, u1;
        logic held, any_latch, any_busy;

        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) tick();
        check_eq("rst_latch", pad_latch, 1'b0);
        check_eq("rst_clk", pad_clk, 1'b0);
        check_eq("rst_p1", pad1_value, 8'h00);
        check_eq("rst_p2", pad2_value, 8'h00);
        check_eq("rst_update", update, 1'b0);
        check_eq("rst_busy", busy, 1'b0);

        reset = 1'b0;
        repeat (5) tick();
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_latch", pad_latch, 1'b0);

        // Frame A: no buttons pressed.
        u0 = upd_cnt;
        enable = 1'b1;
        wait_latch("a_latch_seen");
        trace_frame();
        t_a = cyc;
        check_eq("a_p1", pad1_value, 8'h00);
        check_eq("a_p2", pad2_value, 8'h00);

        // Frames B and C back to back: A+Start on pad 1, Right on pad 2.
        p1_btn = 8'h90;
        p2_btn = 8'h01;
        wait_update("b_update_seen");
        t_b = cyc;
        check_eq("b_spacing", t_b - t_a, SPACING);
        check_eq("b_p1", pad1_value, 8'h90);
        check_eq("b_p2", pad2_value, 8'h01);
        wait_update("c_update_seen");
        t_c = cyc;
        check_eq("c_spacing", t_c - t_b, SPACING);
        tick();
        check_eq("three_updates", upd_cnt - u0, 3);

        // Frame D: pattern changes during shifting; old value must hold until commit.
        wait_latch("d_latch_seen");
        repeat (2 * HP) tick();
        p1_btn = 8'h41;
        held = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (update) break;
            if (pad1_value !== 8'h90) held = 1'b0;
        end
        check_eq("d_update", update, 1'b1);
        check_eq("d_hold_old", held, 1'b1);
        check_eq("d_p1_new", pad1_value, 8'h41);
        check_eq("d_p2", pad2_value, 8'h01);

        // Frame E: enable dropped during bit 3; frame completes, then block idles.
        wait_latch("e_latch_seen");
        repeat (2 * HP + 3 * 2 * HP + 1) tick();
        enable = 1'b0;
        u1 = upd_cnt;
        wait_update("e_update_seen");
        check_eq("e_p1", pad1_value, 8'h41);
        any_latch = 1'b0;
        any_busy = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (pad_latch) any_latch = 1'b1;
            if (busy) any_busy = 1'b1;
        end
        check_eq("e_no_latch", any_latch, 1'b0);
        check_eq("e_no_busy", any_busy, 1'b0);
        check_eq("e_one_update", upd_cnt - u1, 1);

        // Frame F produces 8'h90, then reset hits frame G during bit 5.
        p1_btn = 8'h90;
        enable = 1'b1;
        wait_update("f_update_seen");
        check_eq("f_p1", pad1_value, 8'h90);
        wait_latch("g_latch_seen");
        repeat (2 * HP + 5 * 2 * HP + 1) tick();
        #2;
        reset = 1'b1;
        #1;
        u1 = upd_cnt;
        check_eq("g_rst_p1", pad1_value, 8'h00);
        check_eq("g_rst_p2", pad2_value, 8'h00);
        check_eq("g_rst_latch", pad_latch, 1'b0);
        check_eq("g_rst_clk", pad_clk, 1'b0);
        check_eq("g_rst_busy", busy, 1'b0);
        check_eq("g_rst_update", update, 1'b0);
        repeat (3) tick();
        reset = 1'b0;
        check_eq("g_no_update", upd_cnt - u1, 0);
        tick();
        check_eq("g_latch_after_rst", pad_latch, 1'b1);
        wait_update("h_update_seen");
        check_eq("h_p1", pad1_value, 8'h90);
        check_eq("h_p2", pad2_value, 8'h01);

        tick();
        check_eq("no_overlap", overlap_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
